// File: rtl/uart_alu_frontend_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_alu_frontend_if
// Brief   : RX FIFO, TX FIFO, ALU and status signals of the UART ALU front end.
// Revision: 1.0
// ============================================================================
interface uart_alu_frontend_if #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 6
);
  logic [7:0]        i_rx_data;
  logic              i_rx_empty;
  logic              o_rd;
  logic              i_tx_full;
  logic [7:0]        o_tx_data;
  logic              o_wr;
  logic [DATA_W-1:0] o_op_a;
  logic [DATA_W-1:0] o_op_b;
  logic [OPC_W-1:0]  o_op_code;
  logic [DATA_W-1:0] i_alu_result;
  logic [2:0]        i_alu_flags;
  logic              o_busy;
  logic [DATA_W-1:0] o_last_result;
  logic [7:0]        o_err_cnt;

  modport master (
    input  i_rx_data, i_rx_empty, i_tx_full, i_alu_result, i_alu_flags,
    output o_rd, o_tx_data, o_wr, o_op_a, o_op_b, o_op_code,
           o_busy, o_last_result, o_err_cnt
  );

  modport slave (
    output i_rx_data, i_rx_empty, i_tx_full, i_alu_result, i_alu_flags,
    input  o_rd, o_tx_data, o_wr, o_op_a, o_op_b, o_op_code,
           o_busy, o_last_result, o_err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/uart_alu_frontend.sv
`default_nettype none
// ============================================================================
// Module  : uart_alu_frontend
// Brief   : Parses opcode/A/B frames from an RX FIFO, runs an external ALU and
//           streams the result (plus optional status byte) to a TX FIFO.
// Revision: 1.0
// ============================================================================
module uart_alu_frontend #(
  parameter int DATA_W    = 8,
  parameter int OPC_W     = 6,
  parameter int TIMEOUT   = 1000000,
  parameter int STATUS_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_alu_frontend_if.master  bus
);
  localparam int c_nb    = DATA_W / 8;
  localparam int c_cnt_w = $clog2(c_nb + 1);
  localparam int c_to_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    SEND_R = 3'd4,
    SEND_S = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [c_to_w-1:0]   r_to_cnt;
  logic [OPC_W-1:0]    r_sh_opc;
  logic [DATA_W-1:0]   r_sh_a;
  logic [DATA_W-1:0]   r_sh_b;
  logic [DATA_W-1:0]   w_sh_merge;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [OPC_W-1:0]    r_op_code;
  logic [DATA_W-1:0]   r_res;
  logic [2:0]          r_flags;
  logic [DATA_W-1:0]   r_last_result;
  logic [7:0]          r_err_cnt;
  logic [7:0]          w_tx_data;
  logic                w_rx_state;
  logic                w_tx_state;
  logic                w_pop;
  logic                w_push;
  logic                w_last_byte;
  logic                w_timeout;

  assign w_rx_state  = (r_state == IDLE) || (r_state == GET_A) || (r_state == GET_B);
  assign w_tx_state  = (r_state == SEND_R) || (r_state == SEND_S);
  // Gating with rst_n keeps the FIFO strobes quiet for the whole reset window.
  assign w_pop       = rst_n && w_rx_state && !bus.i_rx_empty;
  assign w_push      = rst_n && w_tx_state && !bus.i_tx_full;
  assign w_last_byte = (r_cnt == c_cnt_w'(c_nb - 1));
  assign w_timeout   = (TIMEOUT != 0) && !w_pop &&
                       ((r_state == GET_A) || (r_state == GET_B)) &&
                       (r_to_cnt == c_to_w'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_pop) w_state_nxt = GET_A;
      GET_A: begin
        if (w_timeout)                w_state_nxt = IDLE;
        else if (w_pop && w_last_byte) w_state_nxt = GET_B;
        else if (w_pop)                w_cnt_nxt   = r_cnt + c_cnt_w'(1);
      end
      GET_B: begin
        if (w_timeout)                w_state_nxt = IDLE;
        else if (w_pop && w_last_byte) w_state_nxt = EXEC;
        else if (w_pop)                w_cnt_nxt   = r_cnt + c_cnt_w'(1);
      end
      EXEC: w_state_nxt = SEND_R;
      SEND_R: begin
        if (w_push && w_last_byte) w_state_nxt = (STATUS_EN != 0) ? SEND_S : IDLE;
        else if (w_push)           w_cnt_nxt   = r_cnt + c_cnt_w'(1);
      end
      SEND_S: if (w_push) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // Incoming byte dropped into the shadow operand currently being filled.
  always_comb begin
    w_sh_merge = (r_state == GET_B) ? r_sh_b : r_sh_a;
    for (int k = 0; k < c_nb; k++) begin
      if (r_cnt == c_cnt_w'(k)) w_sh_merge[8*k +: 8] = bus.i_rx_data;
    end
  end

  always_comb begin
    w_tx_data = '0;
    if (r_state == SEND_S) begin
      w_tx_data = {5'b0, r_flags};
    end else if (r_state == SEND_R) begin
      for (int k = 0; k < c_nb; k++) begin
        if (r_cnt == c_cnt_w'(k)) w_tx_data = r_res[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_sh_opc      <= '0;
      r_sh_a        <= '0;
      r_sh_b        <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_op_code     <= '0;
      r_res         <= '0;
      r_flags       <= '0;
      r_last_result <= '0;
      r_err_cnt     <= '0;
    end else begin
      if (w_pop || (r_state == IDLE))
        r_to_cnt <= '0;
      else if ((r_state == GET_A) || (r_state == GET_B))
        r_to_cnt <= r_to_cnt + c_to_w'(1);

      if (w_timeout) begin
        r_sh_opc <= '0;
        r_sh_a   <= '0;
        r_sh_b   <= '0;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end

      case (r_state)
        IDLE:  if (w_pop) r_sh_opc <= bus.i_rx_data[OPC_W-1:0];
        GET_A: if (w_pop) r_sh_a <= w_sh_merge;
        GET_B: begin
          if (w_pop) begin
            r_sh_b <= w_sh_merge;
            // ALU operands move only here, so they are stable during reception.
            if (w_last_byte) begin
              r_op_a    <= r_sh_a;
              r_op_b    <= w_sh_merge;
              r_op_code <= r_sh_opc;
            end
          end
        end
        EXEC: begin
          r_res         <= bus.i_alu_result;
          r_flags       <= bus.i_alu_flags;
          r_last_result <= bus.i_alu_result;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_rd          = w_pop;
  assign bus.o_wr          = w_push;
  assign bus.o_tx_data     = w_tx_data;
  assign bus.o_op_a        = r_op_a;
  assign bus.o_op_b        = r_op_b;
  assign bus.o_op_code     = r_op_code;
  assign bus.o_busy        = (r_state != IDLE);
  assign bus.o_last_result = r_last_result;
  assign bus.o_err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_frontend.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_alu_frontend
// Brief   : Self-checking bench: FIFO/ALU environment plus frame-level model.
// Revision: 1.0
// ============================================================================
module tb_uart_alu_frontend;
  localparam int c_dw = 16;
  localparam int c_ow = 6;
  localparam int c_nb = c_dw / 8;
  localparam int c_fl = 1 + 2 * c_nb;
  localparam int c_rl = c_nb + 1;
  localparam int c_to = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_alu_frontend_if #(.DATA_W(c_dw), .OPC_W(c_ow)) bus ();

  uart_alu_frontend #(
    .DATA_W(c_dw), .OPC_W(c_ow), .TIMEOUT(c_to), .STATUS_EN(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference ALU: returns {overflow, carry, zero, result}.
  function automatic logic [c_dw+2:0] alu_ref(input logic [c_ow-1:0] opc,
                                              input logic [c_dw-1:0] a,
                                              input logic [c_dw-1:0] b);
    logic [c_dw:0]   wide;
    logic [c_dw-1:0] r;
    logic            c;
    logic            v;
    wide = '0; c = 1'b0; v = 1'b0;
    case (opc[1:0])
      2'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[c_dw-1:0];
        c = wide[c_dw];
        v = (a[c_dw-1] == b[c_dw-1]) && (r[c_dw-1] != a[c_dw-1]);
      end
      2'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[c_dw-1] != b[c_dw-1]) && (r[c_dw-1] != a[c_dw-1]);
      end
      2'd2:    r = a & b;
      default: r = a ^ b;
    endcase
    return {v, c, (r == '0), r};
  endfunction

  always_comb {bus.i_alu_flags, bus.i_alu_result} = alu_ref(bus.o_op_code, bus.o_op_a, bus.o_op_b);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Environment state: RX FIFO contents, TX log and protocol counters.
  logic [7:0] rx_mem [0:1023];
  logic [7:0] tx_log [0:1023];
  logic [7:0] exp_mem[0:1023];
  int rx_wr = 0, rx_rd = 0, exp_n = 0, tx_chk = 0;
  int cyc = 0, pops = 0, wrs = 0, base_pops = 0, base_wrs = 0;
  int frame_end_cyc = 0, resp_start_cyc = 0;
  int rd_busy_viol = 0, rd_empty_viol = 0, wr_full_viol = 0;
  logic force_full = 1'b0;
  logic rand_full  = 1'b0;

  logic [c_dw-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [c_ow-1:0] m_opc = '0;
  logic [7:0]      m_err = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_rd) begin
      if (bus.i_rx_empty) rd_empty_viol <= rd_empty_viol + 1;
      if (((pops - base_pops) % c_fl == 0) &&
          ((pops - base_pops) / c_fl > (wrs - base_wrs) / c_rl))
        rd_busy_viol <= rd_busy_viol + 1;
      if (((pops - base_pops) % c_fl) == c_fl - 1) frame_end_cyc <= cyc;
      if (rx_rd != rx_wr) rx_rd <= rx_rd + 1;
      pops <= pops + 1;
    end
    if (bus.o_wr) begin
      if (bus.i_tx_full) wr_full_viol <= wr_full_viol + 1;
      if (((wrs - base_wrs) % c_rl) == 0) resp_start_cyc <= cyc;
      tx_log[wrs] <= bus.o_tx_data;
      wrs <= wrs + 1;
    end
  end

  initial begin
    bus.i_rx_empty = 1'b1;
    bus.i_rx_data  = 8'h00;
    bus.i_tx_full  = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_rx_empty = (rx_rd == rx_wr);
      bus.i_rx_data  = (rx_rd == rx_wr) ? 8'h00 : rx_mem[rx_rd];
      bus.i_tx_full  = force_full || (rand_full && ($urandom_range(0, 2) == 0));
    end
  end

  task automatic push_byte(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic push_frame(input logic [7:0] opc, input logic [c_dw-1:0] a,
                            input logic [c_dw-1:0] b, input int gap);
    logic [c_dw+2:0] r;
    push_byte(opc);
    for (int k = 0; k < c_nb; k++) begin
      repeat ($urandom_range(0, gap)) @(negedge clk);
      push_byte(a[8*k +: 8]);
    end
    for (int k = 0; k < c_nb; k++) begin
      repeat ($urandom_range(0, gap)) @(negedge clk);
      push_byte(b[8*k +: 8]);
    end
    r = alu_ref(opc[c_ow-1:0], a, b);
    for (int k = 0; k < c_nb; k++) begin
      exp_mem[exp_n] = r[8*k +: 8];
      exp_n = exp_n + 1;
    end
    exp_mem[exp_n] = {5'b0, r[c_dw+2:c_dw]};
    exp_n = exp_n + 1;
    m_a = a; m_b = b; m_opc = opc[c_ow-1:0]; m_res = r[c_dw-1:0];
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pops < target && n < 2000) begin @(negedge clk); n++; end
    if (pops < target) chk("wait_pops", pops, target);
  endtask

  task automatic wait_wrs(input int target);
    int n = 0;
    while (wrs < target && n < 4000) begin @(negedge clk); n++; end
    if (wrs < target) chk("wait_wrs", wrs, target);
  endtask

  task automatic check_resp(input string tag);
    wait_wrs(exp_n);
    repeat (2) @(negedge clk);
    #2;
    chk({tag, "_op_a"}, bus.o_op_a, m_a);
    chk({tag, "_op_b"}, bus.o_op_b, m_b);
    chk({tag, "_op_code"}, bus.o_op_code, m_opc);
    chk({tag, "_last_result"}, bus.o_last_result, m_res);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
    for (int k = tx_chk; k < exp_n && k < wrs; k++) chk({tag, "_tx"}, tx_log[k], exp_mem[k]);
    tx_chk = exp_n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got n_chk=%0d expected completion", n_chk);
    $fatal(1);
  end

  initial begin
    int t;
    int w0;
    rst_n = 1'b0;
    // Frame queued while reset is held: it must not be popped until release.
    push_frame(8'h20, 16'h1234, 16'h0001, 0);
    repeat (3) @(negedge clk);
    #2;
    chk("rst_rd", bus.o_rd, 1'b0);
    chk("rst_wr", bus.o_wr, 1'b0);
    chk("rst_tx_data", bus.o_tx_data, 8'h00);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_op_a", bus.o_op_a, 16'h0);
    chk("rst_op_b", bus.o_op_b, 16'h0);
    chk("rst_op_code", bus.o_op_code, 6'h0);
    chk("rst_last_result", bus.o_last_result, 16'h0);
    chk("rst_err_cnt", bus.o_err_cnt, 8'h0);
    chk("rst_no_pop", pops, 0);
    @(negedge clk);
    rst_n = 1'b1;

    check_resp("w16");
    chk("w16_result_const", bus.o_last_result, 16'h1235);
    chk("w16_tx_lsb", tx_log[0], 8'h35);
    chk("w16_tx_msb", tx_log[1], 8'h12);
    chk("w16_tx_status", tx_log[2], 8'h00);
    chk("latency", resp_start_cyc - frame_end_cyc, 2);

    // Back-pressure: TX full across the whole response window.
    force_full = 1'b1;
    t = pops + c_fl;
    push_frame(8'h00, 16'hFFF0, 16'h0020, 0);
    wait_pops(t);
    w0 = wrs;
    repeat (10) @(negedge clk);
    chk("bp_no_wr", wrs, w0);
    chk("bp_busy", bus.o_busy, 1'b1);
    force_full = 1'b0;
    check_resp("bp");

    // Timeout after opcode + one A byte.
    t = pops + 2;
    push_byte(8'h02);
    push_byte(8'h55);
    wait_pops(t);
    repeat (45) @(negedge clk);
    #2;
    chk("to_still_busy", bus.o_busy, 1'b1);
    repeat (10) @(negedge clk);
    #2;
    m_err = 8'd1;
    chk("to_idle", bus.o_busy, 1'b0);
    chk("to_err_cnt", bus.o_err_cnt, m_err);
    chk("to_op_a_kept", bus.o_op_a, m_a);
    chk("to_op_b_kept", bus.o_op_b, m_b);
    chk("to_op_code_kept", bus.o_op_code, m_opc);
    base_pops = pops;
    base_wrs  = wrs;
    push_frame(8'h01, 16'h0005, 16'h0007, 2);
    check_resp("after_to");
    chk("after_to_err_cnt", bus.o_err_cnt, m_err);

    // Reset right after the B LSB byte.
    t = pops + 4;
    push_byte(8'h00);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    wait_pops(t);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.o_busy, 1'b0);
    chk("mid_rst_op_a", bus.o_op_a, 16'h0);
    chk("mid_rst_op_b", bus.o_op_b, 16'h0);
    chk("mid_rst_last", bus.o_last_result, 16'h0);
    chk("mid_rst_err", bus.o_err_cnt, 8'h0);
    chk("mid_rst_rd", bus.o_rd, 1'b0);
    chk("mid_rst_wr", bus.o_wr, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_err = '0;
    base_pops = pops;
    base_wrs  = wrs;
    push_frame(8'h22, 16'hF0F0, 16'h3C3C, 1);
    check_resp("after_rst");

    // Two frames preloaded back to back; the second yields a zero result.
    push_frame(8'hE1, 16'h0003, 16'h0009, 0);
    push_frame(8'h03, 16'hA5A5, 16'hA5A5, 0);
    check_resp("b2b");

    rand_full = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_frame(8'($urandom), c_dw'($urandom), c_dw'($urandom), 4);
      check_resp("rnd");
    end
    rand_full = 1'b0;

    repeat (20) @(negedge clk);
    chk("tx_total", wrs, exp_n);
    chk("rd_during_busy", rd_busy_viol, 0);
    chk("rd_on_empty", rd_empty_viol, 0);
    chk("wr_on_full", wr_full_viol, 0);
    chk("err_cnt_final", bus.o_err_cnt, m_err);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
